uart_fifo_bridge: RTL and testbench

Buffered byte-stream bridge between the CPU's memory-mapped I/O logic and the UART core. It holds a TX FIFO that feeds the core's transmit handshake (`tx_data`/`tx_wr`/`tx_busy`). It holds an RX FIFO that drains the core's receive handshake (`rx_data`/`rx_avail`/`rx_error`/`rx_ack`). The CPU can therefore write bursts and read received bytes without polling per character. Sticky error flags report RX overrun, framing errors and TX overflow.

---
 rtl/uart_fifo_bridge_if.sv | 45 ++++
 rtl/uart_fifo_bridge.sv | 177 +++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_bridge_if.sv
// Bus bundle between the CPU-side I/O logic, the UART core and the bridge.
// The slave modport is the bridge's view; the master modport is the
// CPU and core side, which drives what the bridge consumes.
interface uart_fifo_bridge_if #(
    parameter int DEPTH_LOG2 = 4
);
    // CPU side
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                rd_en;
    logic [7:0]          rd_data;
    logic                rx_empty;
    logic                tx_full;
    logic [DEPTH_LOG2:0] rx_count;
    logic [DEPTH_LOG2:0] tx_count;
    logic                tx_idle;
    logic                clr_flags;
    logic                rx_overrun;
    logic                rx_frame_err;
    logic                tx_overflow;
    // UART core side
    logic [7:0]          u_tx_data;
    logic                u_tx_wr;
    logic                u_tx_busy;
    logic [7:0]          u_rx_data;
    logic                u_rx_avail;
    logic                u_rx_error;
    logic                u_rx_ack;

    modport slave (
        input  wr_data, wr_en, rd_en, clr_flags,
        input  u_tx_busy, u_rx_data, u_rx_avail, u_rx_error,
        output rd_data, rx_empty, tx_full, rx_count, tx_count, tx_idle,
        output rx_overrun, rx_frame_err, tx_overflow,
        output u_tx_data, u_tx_wr, u_rx_ack
    );

    modport master (
        output wr_data, wr_en, rd_en, clr_flags,
        output u_tx_busy, u_rx_data, u_rx_avail, u_rx_error,
        input  rd_data, rx_empty, tx_full, rx_count, tx_count, tx_idle,
        input  rx_overrun, rx_frame_err, tx_overflow,
        input  u_tx_data, u_tx_wr, u_rx_ack
    );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Buffered byte bridge between CPU I/O logic and a UART core: a TX FIFO
// drained into the core's write handshake, an RX FIFO filled from the
// core's receive handshake, and sticky error flags.
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic               clk,
    input logic               reset,
    uart_fifo_bridge_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    typedef enum logic [1:0] {TxIdle, TxStart, TxDrain} tx_state_t;
    typedef enum logic       {RxIdle, RxAck}            rx_state_t;

    // ---------------- TX side ----------------
    logic [7:0] tx_mem [DEPTH];
    ptr_t       tx_wptr_q, tx_rptr_q;
    cnt_t       tx_cnt_q;
    tx_state_t  tx_state_q;
    logic [7:0] u_tx_data_q;
    logic       u_tx_wr_q;
    logic       tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    // The FSM pops the head in the same cycle it launches the core write.
    assign tx_pop   = (tx_state_q == TxIdle) && !tx_empty && !bus.u_tx_busy;
    // A full FIFO still accepts a write if the head leaves in that cycle.
    assign tx_push    = bus.wr_en && (!tx_full || tx_pop);
    assign tx_ovf_set = bus.wr_en && !tx_push;

    // TX storage write (contents need no reset; count qualifies them)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= bus.wr_data;
    end

    // TX pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + ptr_t'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + ptr_t'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + cnt_t'(1);
                2'b01:   tx_cnt_q <= tx_cnt_q - cnt_t'(1);
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // TX FSM: one-cycle write strobe, then track the core's busy pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= TxIdle;
            u_tx_wr_q   <= 1'b0;
            u_tx_data_q <= 8'h00;
        end else begin
            u_tx_wr_q <= 1'b0;
            case (tx_state_q)
                TxIdle: begin
                    if (tx_pop) begin
                        u_tx_data_q <= tx_mem[tx_rptr_q];
                        u_tx_wr_q   <= 1'b1;
                        tx_state_q  <= TxStart;
                    end
                end
                TxStart: if (bus.u_tx_busy)  tx_state_q <= TxDrain;
                TxDrain: if (!bus.u_tx_busy) tx_state_q <= TxIdle;
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    // ---------------- RX side ----------------
    logic [7:0] rx_mem [DEPTH];
    ptr_t       rx_wptr_q, rx_rptr_q;
    cnt_t       rx_cnt_q;
    rx_state_t  rx_state_q;
    logic       u_rx_ack_q;
    logic       rx_full, rx_empty, rx_take, rx_push, rx_pop;
    logic       rx_ovr_set, rx_ferr_set;

    assign rx_full     = (rx_cnt_q == FULL_CNT);
    assign rx_empty    = (rx_cnt_q == '0);
    assign rx_pop      = bus.rd_en && !rx_empty;
    // Only sample the core in IDLE; during ACK avail is still up for the same byte.
    assign rx_take     = (rx_state_q == RxIdle) && bus.u_rx_avail;
    assign rx_push     = rx_take && (!rx_full || rx_pop);
    assign rx_ovr_set  = rx_take && rx_full && !rx_pop;
    assign rx_ferr_set = (rx_state_q == RxIdle) && !bus.u_rx_avail && bus.u_rx_error;

    // RX storage write
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= bus.u_rx_data;
    end

    // RX pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + ptr_t'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + ptr_t'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + cnt_t'(1);
                2'b01:   rx_cnt_q <= rx_cnt_q - cnt_t'(1);
                default: rx_cnt_q <= rx_cnt_q;
            endcase
        end
    end

    // RX FSM: acknowledge every byte or error event for exactly one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            u_rx_ack_q <= 1'b0;
        end else begin
            case (rx_state_q)
                RxIdle: begin
                    if (bus.u_rx_avail || bus.u_rx_error) begin
                        rx_state_q <= RxAck;
                        u_rx_ack_q <= 1'b1;
                    end
                end
                RxAck: begin
                    rx_state_q <= RxIdle;
                    u_rx_ack_q <= 1'b0;
                end
                default: begin
                    rx_state_q <= RxIdle;
                    u_rx_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- Sticky flags ----------------
    logic rx_overrun_q, rx_frame_err_q, tx_overflow_q;

    // A set event in the same cycle as clr_flags wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
        end else begin
            rx_overrun_q   <= rx_ovr_set  || (rx_overrun_q   && !bus.clr_flags);
            rx_frame_err_q <= rx_ferr_set || (rx_frame_err_q && !bus.clr_flags);
            tx_overflow_q  <= tx_ovf_set  || (tx_overflow_q  && !bus.clr_flags);
        end
    end

    // ---------------- Outputs ----------------
    assign bus.rd_data      = rx_mem[rx_rptr_q];
    assign bus.rx_empty     = rx_empty;
    assign bus.tx_full      = tx_full;
    assign bus.rx_count     = rx_cnt_q;
    assign bus.tx_count     = tx_cnt_q;
    assign bus.tx_idle      = tx_empty && (tx_state_q == TxIdle);
    assign bus.rx_overrun   = rx_overrun_q;
    assign bus.rx_frame_err = rx_frame_err_q;
    assign bus.tx_overflow  = tx_overflow_q;
    assign bus.u_tx_data    = u_tx_data_q;
    assign bus.u_tx_wr      = u_tx_wr_q;
    assign bus.u_rx_ack     = u_rx_ack_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed self-checking bench for uart_fifo_bridge with a small UART core model.
module tb_uart_fifo_bridge;
    logic clk;
    logic reset;

    uart_fifo_bridge_if #(.DEPTH_LOG2(4)) bus ();

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    // Core model / monitor state
    bit         core_hold  = 1'b0;
    int         busy_timer = 0;
    bit         wr_seen    = 1'b0;
    bit         wr_prev    = 1'b0;
    int         pulse_cnt  = 0;
    int         width_viol = 0;
    int         busy_viol  = 0;
    logic [7:0] txq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // TX core model: busy rises one cycle after a write and lasts 3 cycles;
    // core_hold forces busy high. Also records every write strobe.
    initial begin
        bus.u_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            wr_seen = bus.u_tx_wr;
            if (wr_seen) begin
                pulse_cnt++;
                txq.push_back(bus.u_tx_data);
                if (bus.u_tx_busy) busy_viol++;
                if (wr_prev) width_viol++;
            end
            wr_prev = wr_seen;
            @(posedge clk);
            #2;
            if (reset) busy_timer = 0;
            else if (wr_seen) busy_timer = 3;
            else if (busy_timer != 0) busy_timer--;
            bus.u_tx_busy = core_hold || (busy_timer != 0);
        end
    end

    // Core presents a byte and holds avail until the ack cycle has ended
    task automatic rx_send(input logic [7:0] d, input bit with_rd, output int acks,
                           output bit first_ok);
        bus.u_rx_data  = d;
        bus.u_rx_avail = 1'b1;
        bus.rd_en      = with_rd;
        @(posedge clk); #1;
        acks     = int'(bus.u_rx_ack);
        first_ok = bus.u_rx_ack && !bus.rx_empty && (bus.rd_data == d);
        bus.rd_en = 1'b0;
        @(posedge clk); #1;
        acks += int'(bus.u_rx_ack);
        bus.u_rx_avail = 1'b0;
        @(posedge clk); #1;
        acks += int'(bus.u_rx_ack);
    endtask

    // Core reports a framing error (no data) until the ack cycle has ended
    task automatic rx_err(input bit with_clr, output int acks);
        bus.u_rx_error = 1'b1;
        bus.clr_flags  = with_clr;
        @(posedge clk); #1;
        acks = int'(bus.u_rx_ack);
        bus.clr_flags = 1'b0;
        @(posedge clk); #1;
        acks += int'(bus.u_rx_ack);
        bus.u_rx_error = 1'b0;
        @(posedge clk); #1;
        acks += int'(bus.u_rx_ack);
    endtask

    task automatic test_reset();
        logic [7:0] st;
        st = {bus.rx_empty, bus.tx_full, bus.tx_idle, bus.rx_overrun, bus.rx_frame_err,
              bus.tx_overflow, bus.u_tx_wr, bus.u_rx_ack};
        total++;
        if (st !== 8'b1010_0000) $display("FAIL reset_status: got %b want %b", st, 8'b1010_0000);
        else passed++;
        total++;
        if ({bus.rx_count, bus.tx_count} !== 10'd0)
            $display("FAIL reset_counts: got rx=%0d tx=%0d want 0 0", bus.rx_count, bus.tx_count);
        else passed++;
        total++;
        if (bus.u_tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.u_tx_data);
        else passed++;
    endtask

    task automatic test_tx_burst();
        int base;
        int n;
        logic [7:0] got;
        txq.delete();
        base = pulse_cnt;
        core_hold = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'h41 + 8'(i);
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
        total++;
        if (bus.tx_count !== 5'd3) $display("FAIL burst_count: got %0d want 3", bus.tx_count);
        else passed++;
        total++;
        if ({bus.u_tx_wr, bus.tx_idle} !== 2'b00 || pulse_cnt != base)
            $display("FAIL burst_held: got wr=%b idle=%b pulses=%0d want 0 0 0",
                     bus.u_tx_wr, bus.tx_idle, pulse_cnt - base);
        else passed++;
        core_hold = 1'b0;
        n = 0;
        while (n < 100 && !((pulse_cnt - base == 3) && bus.tx_idle)) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 100) $display("FAIL burst_timeout: got %0d cycles want <100", n);
        else passed++;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (pulse_cnt - base != 3) $display("FAIL burst_pulses: got %0d want 3", pulse_cnt - base);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            got = (i < txq.size()) ? txq[i] : 8'hxx;
            total++;
            if (got !== 8'h41 + 8'(i))
                $display("FAIL burst_byte%0d: got %h want %h", i, got, 8'h41 + 8'(i));
            else passed++;
        end
        total++;
        if (width_viol != 0 || busy_viol != 0)
            $display("FAIL burst_handshake: got width_viol=%0d busy_viol=%0d want 0 0",
                     width_viol, busy_viol);
        else passed++;
        total++;
        if ({bus.tx_idle, bus.tx_count} !== {1'b1, 5'd0})
            $display("FAIL burst_idle: got idle=%b count=%0d want 1 0", bus.tx_idle, bus.tx_count);
        else passed++;
    endtask

    task automatic test_tx_overflow();
        int base;
        int n;
        logic [7:0] got;
        core_hold = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'h10 + 8'(i);
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
        total++;
        if ({bus.tx_full, bus.tx_count, bus.tx_overflow} !== {1'b1, 5'd16, 1'b0})
            $display("FAIL ovf_full: got full=%b count=%0d ovf=%b want 1 16 0",
                     bus.tx_full, bus.tx_count, bus.tx_overflow);
        else passed++;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hEE;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        total++;
        if ({bus.tx_overflow, bus.tx_count} !== {1'b1, 5'd16})
            $display("FAIL ovf_set: got ovf=%b count=%0d want 1 16", bus.tx_overflow, bus.tx_count);
        else passed++;
        bus.clr_flags = 1'b1;
        @(posedge clk); #1;
        bus.clr_flags = 1'b0;
        total++;
        if (bus.tx_overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", bus.tx_overflow);
        else passed++;
        txq.delete();
        base = pulse_cnt;
        core_hold = 1'b0;
        n = 0;
        while (n < 400 && !((pulse_cnt - base == 16) && bus.tx_idle)) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 400) $display("FAIL ovf_drain_timeout: got %0d cycles want <400", n);
        else passed++;
        for (int i = 0; i < 16; i += 5) begin
            got = (i < txq.size()) ? txq[i] : 8'hxx;
            total++;
            if (got !== 8'h10 + 8'(i))
                $display("FAIL ovf_byte%0d: got %h want %h", i, got, 8'h10 + 8'(i));
            else passed++;
        end
        total++;
        if (txq.size() != 16 || busy_viol != 0 || width_viol != 0)
            $display("FAIL ovf_drain: got n=%0d busy_viol=%0d width_viol=%0d want 16 0 0",
                     txq.size(), busy_viol, width_viol);
        else passed++;
    endtask

    task automatic test_rx_single();
        int acks;
        bit first_ok;
        rx_send(8'h5A, 1'b0, acks, first_ok);
        total++;
        if (acks != 1 || !first_ok)
            $display("FAIL rx_single_ack: got acks=%0d first_ok=%b want 1 1", acks, first_ok);
        else passed++;
        total++;
        if ({bus.rx_count, bus.rd_data, bus.rx_empty} !== {5'd1, 8'h5A, 1'b0})
            $display("FAIL rx_single_data: got count=%0d data=%h empty=%b want 1 5a 0",
                     bus.rx_count, bus.rd_data, bus.rx_empty);
        else passed++;
        bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        total++;
        if ({bus.rx_empty, bus.rx_count} !== {1'b1, 5'd0})
            $display("FAIL rx_single_pop: got empty=%b count=%0d want 1 0", bus.rx_empty, bus.rx_count);
        else passed++;
        bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        total++;
        if ({bus.rx_empty, bus.rx_count, bus.rx_overrun, bus.rx_frame_err} !== {1'b1, 5'd0, 2'b00})
            $display("FAIL rx_empty_read: got empty=%b count=%0d ovr=%b ferr=%b want 1 0 0 0",
                     bus.rx_empty, bus.rx_count, bus.rx_overrun, bus.rx_frame_err);
        else passed++;
    endtask

    task automatic test_rx_overrun();
        int acks;
        int sum;
        bit ok;
        logic [7:0] exp;
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            rx_send(8'h80 + 8'(i), 1'b0, acks, ok);
            sum += acks;
        end
        total++;
        if (sum != 16 || bus.rx_count !== 5'd16 || bus.rx_overrun !== 1'b0)
            $display("FAIL ovr_fill: got acks=%0d count=%0d ovr=%b want 16 16 0",
                     sum, bus.rx_count, bus.rx_overrun);
        else passed++;
        rx_send(8'hEE, 1'b0, acks, ok);
        total++;
        if (acks != 1 || bus.rx_count !== 5'd16 || bus.rx_overrun !== 1'b1)
            $display("FAIL ovr_drop: got acks=%0d count=%0d ovr=%b want 1 16 1",
                     acks, bus.rx_count, bus.rx_overrun);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (bus.rd_data !== 8'h80 + 8'(i))
                $display("FAIL ovr_order%0d: got %h want %h", i, bus.rd_data, 8'h80 + 8'(i));
            else passed++;
            bus.rd_en = 1'b1;
            @(posedge clk); #1;
        end
        bus.rd_en = 1'b0;
        bus.clr_flags = 1'b1;
        @(posedge clk); #1;
        bus.clr_flags = 1'b0;
        total++;
        if ({bus.rx_empty, bus.rx_overrun} !== 2'b10)
            $display("FAIL ovr_clear: got empty=%b ovr=%b want 1 0", bus.rx_empty, bus.rx_overrun);
        else passed++;
        for (int i = 0; i < 16; i++) rx_send(8'h20 + 8'(i), 1'b0, acks, ok);
        rx_send(8'h77, 1'b1, acks, ok);
        total++;
        if (bus.rx_count !== 5'd16 || bus.rx_overrun !== 1'b0)
            $display("FAIL ovr_with_pop: got count=%0d ovr=%b want 16 0", bus.rx_count, bus.rx_overrun);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'h21 + 8'(i) : 8'h77;
            total++;
            if (bus.rd_data !== exp)
                $display("FAIL pop_order%0d: got %h want %h", i, bus.rd_data, exp);
            else passed++;
            bus.rd_en = 1'b1;
            @(posedge clk); #1;
        end
        bus.rd_en = 1'b0;
        total++;
        if (bus.rx_empty !== 1'b1) $display("FAIL pop_empty: got %b want 1", bus.rx_empty);
        else passed++;
    endtask

    task automatic test_frame_err();
        int acks;
        rx_err(1'b0, acks);
        total++;
        if (acks != 1 || bus.rx_frame_err !== 1'b1)
            $display("FAIL ferr_set: got acks=%0d ferr=%b want 1 1", acks, bus.rx_frame_err);
        else passed++;
        total++;
        if ({bus.rx_empty, bus.rx_count} !== {1'b1, 5'd0})
            $display("FAIL ferr_fifo: got empty=%b count=%0d want 1 0", bus.rx_empty, bus.rx_count);
        else passed++;
        bus.clr_flags = 1'b1;
        @(posedge clk); #1;
        bus.clr_flags = 1'b0;
        total++;
        if (bus.rx_frame_err !== 1'b0) $display("FAIL ferr_clear: got %b want 0", bus.rx_frame_err);
        else passed++;
        rx_err(1'b1, acks);
        total++;
        if (bus.rx_frame_err !== 1'b1)
            $display("FAIL ferr_set_wins: got %b want 1", bus.rx_frame_err);
        else passed++;
    endtask

    task automatic test_async_reset();
        int acks;
        int base;
        int glitch;
        bit ok;
        logic [7:0] st;
        rx_send(8'h33, 1'b0, acks, ok);
        for (int i = 0; i < 6; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'h60 + 8'(i);
            if (i == 3) core_hold = 1'b1;
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
        total++;
        if ({bus.tx_count, bus.tx_idle, bus.rx_count} !== {5'd5, 1'b0, 5'd1})
            $display("FAIL arst_pre: got tx=%0d idle=%b rx=%0d want 5 0 1",
                     bus.tx_count, bus.tx_idle, bus.rx_count);
        else passed++;
        #3;
        reset = 1'b1;
        #1;
        st = {bus.rx_empty, bus.tx_full, bus.tx_idle, bus.rx_overrun, bus.rx_frame_err,
              bus.tx_overflow, bus.u_tx_wr, bus.u_rx_ack};
        total++;
        if (st !== 8'b1010_0000) $display("FAIL arst_status: got %b want %b", st, 8'b1010_0000);
        else passed++;
        total++;
        if ({bus.rx_count, bus.tx_count, bus.u_tx_data} !== 18'd0)
            $display("FAIL arst_counts: got rx=%0d tx=%0d data=%h want 0 0 00",
                     bus.rx_count, bus.tx_count, bus.u_tx_data);
        else passed++;
        @(posedge clk); #1;
        reset     = 1'b0;
        core_hold = 1'b0;
        base      = pulse_cnt;
        glitch    = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.u_tx_wr || bus.u_rx_ack) glitch++;
            @(posedge clk); #1;
        end
        total++;
        if (glitch != 0 || pulse_cnt != base || bus.tx_idle !== 1'b1)
            $display("FAIL arst_release: got glitch=%0d pulses=%0d idle=%b want 0 0 1",
                     glitch, pulse_cnt - base, bus.tx_idle);
        else passed++;
    endtask

    initial begin
        reset          = 1'b1;
        bus.wr_data    = 8'h00;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.clr_flags  = 1'b0;
        bus.u_rx_data  = 8'h00;
        bus.u_rx_avail = 1'b0;
        bus.u_rx_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_tx_burst();
        test_tx_overflow();
        test_rx_single();
        test_rx_overrun();
        test_frame_err();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
